// File: rtl/lsu_avalon_ctrl.sv
// Sequential MIPS load/store unit: one instruction at a time, one Avalon-MM
// transfer with waitrequest handling, alignment checks and a bus watchdog.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for a new instruction
// S_CHECK  | decode op, check alignment
// S_ACCESS | bus strobe held until waitrequest drops or watchdog fires
// S_RESP   | retire: done pulse, register writeback for loads
// S_ERR    | retire with fault code, no writeback
module lsu_avalon_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ALIGN_CHECK    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [15:0]       req_offset,
    input  logic [4:0]        req_rt,
    input  logic [31:0]       req_rt_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic              wb_valid,
    output logic [4:0]        wb_rt,
    output logic [31:0]       wb_data,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_SWL = 4'd11;
    localparam logic [3:0] OP_SWR = 4'd12;

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [2:0]        state;
    logic [3:0]        op_q;
    logic [4:0]        rt_q;
    logic [31:0]       rt_data_q;
    logic [ADDR_W-1:0] ea_q;
    logic [31:0]       rdata_q;
    logic [1:0]        code_q;
    logic [CNT_W-1:0]  wd_cnt;
    logic [CNT_W-1:0]  wd_nxt;

    logic [ADDR_W-1:0] off_ext;
    logic [1:0]        k;
    logic [4:0]        sh;
    logic              is_load;
    logic              is_store;
    logic              illegal;
    logic              misaligned;
    logic              in_access;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       ldata;
    logic [31:0]       byte_sel;
    logic [15:0]       half_sel;

    assign off_ext   = ADDR_W'($signed(req_offset));
    assign k         = ea_q[1:0];
    assign sh        = {k, 3'b000};
    assign is_load   = (op_q <= OP_LWR);
    assign is_store  = (op_q >= OP_SB) && (op_q <= OP_SWR);
    assign illegal   = !(is_load || is_store);
    assign wd_nxt    = wd_cnt + 1'b1;
    assign byte_sel  = rdata_q >> sh;
    assign half_sel  = k[1] ? rdata_q[31:16] : rdata_q[15:0];
    assign in_access = (state == S_ACCESS);

    always_comb begin
        be         = 4'b0000;
        wdata      = 32'h0;
        ldata      = 32'h0;
        misaligned = 1'b0;
        case (op_q)
            OP_LB:  begin be = 4'b0001 << k; ldata = {{24{byte_sel[7]}}, byte_sel[7:0]}; end
            OP_LBU: begin be = 4'b0001 << k; ldata = {24'h0, byte_sel[7:0]}; end
            OP_LH:  begin be = k[1] ? 4'b1100 : 4'b0011; ldata = {{16{half_sel[15]}}, half_sel}; end
            OP_LHU: begin be = k[1] ? 4'b1100 : 4'b0011; ldata = {16'h0, half_sel}; end
            OP_LW:  begin be = 4'b1111; ldata = rdata_q; end
            // LWL fills rt from the top, LWR from the bottom; untouched bytes keep rt
            OP_LWL: begin
                be    = 4'b1111 >> (2'd3 - k);
                ldata = (rdata_q << (5'd24 - sh)) | (rt_data_q & (32'h00FF_FFFF >> sh));
            end
            OP_LWR: begin
                be    = 4'b1111 << k;
                ldata = (rdata_q >> sh) | (rt_data_q & ~(32'hFFFF_FFFF >> sh));
            end
            OP_SB:  begin be = 4'b0001 << k; wdata = {4{rt_data_q[7:0]}}; end
            OP_SH:  begin be = k[1] ? 4'b1100 : 4'b0011; wdata = {2{rt_data_q[15:0]}}; end
            OP_SW:  begin be = 4'b1111; wdata = rt_data_q; end
            OP_SWL: begin be = 4'b1111 >> (2'd3 - k); wdata = rt_data_q >> (5'd24 - sh); end
            OP_SWR: begin be = 4'b1111 << k; wdata = rt_data_q << sh; end
            default: ;
        endcase
        if (ALIGN_CHECK != 0) begin
            case (op_q)
                OP_LH, OP_LHU, OP_SH: misaligned = k[0];
                OP_LW, OP_SW:         misaligned = |k;
                default:              misaligned = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= 4'h0;
            rt_q      <= 5'h0;
            rt_data_q <= 32'h0;
            ea_q      <= '0;
            rdata_q   <= 32'h0;
            code_q    <= 2'b00;
            wd_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    op_q      <= req_op;
                    rt_q      <= req_rt;
                    rt_data_q <= req_rt_data;
                    ea_q      <= req_base + off_ext;
                    wd_cnt    <= '0;
                    state     <= S_CHECK;
                end
                S_CHECK: begin
                    if (illegal) begin
                        code_q <= 2'b11;
                        state  <= S_ERR;
                    end else if (misaligned) begin
                        code_q <= 2'b01;
                        state  <= S_ERR;
                    end else begin
                        state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!avm_waitrequest) begin
                        if (is_load) rdata_q <= avm_readdata;
                        state <= S_RESP;
                    end else begin
                        wd_cnt <= wd_nxt;
                        if (TIMEOUT_CYCLES != 0 && wd_nxt == TO_VAL) begin
                            code_q <= 2'b10;
                            state  <= S_ERR;
                        end
                    end
                end
                S_RESP, S_ERR: state <= S_IDLE;
                default:       state <= S_IDLE;
            endcase
        end
    end

    // Bus strobes decode straight from state so an async reset drops them at once
    assign req_ready      = (state == S_IDLE);
    assign avm_read       = in_access && is_load;
    assign avm_write      = in_access && is_store;
    assign avm_address    = in_access ? {ea_q[ADDR_W-1:2], 2'b00} : '0;
    assign avm_byteenable = in_access ? be : 4'b0000;
    assign avm_writedata  = (in_access && is_store) ? wdata : 32'h0;
    assign wb_valid       = (state == S_RESP) && is_load && (rt_q != 5'd0);
    assign wb_rt          = wb_valid ? rt_q : 5'd0;
    assign wb_data        = wb_valid ? ldata : 32'h0;
    assign done           = (state == S_RESP) || (state == S_ERR);
    assign err            = (state == S_ERR);
    assign err_code       = (state == S_ERR) ? code_q : 2'b00;
endmodule
